// File: rtl/e_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types and constants for the E-stage multiply/divide
//               unit: op encoding, default latencies and counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
  localparam int MDU_CNT_W       = 4;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  // True for the ops that occupy the unit for a multi-cycle period
  function automatic logic is_muldiv(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/e_mdu_if.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu_if
// Description : E-stage <-> MDU signal bundle. master = pipeline side,
//               slave = the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface e_mdu_if;
  import mdu_pkg::*;

  mdu_op_e     E_mdu_op;
  logic        E_valid;
  logic [31:0] E_src1;
  logic [31:0] E_src2;
  logic        D_is_mdu;
  logic [31:0] E_mdu_result;
  logic        E_mdu_busy;
  logic        D_mdu_stall;

  modport master (
    output E_mdu_op, E_valid, E_src1, E_src2, D_is_mdu,
    input  E_mdu_result, E_mdu_busy, D_mdu_stall
  );

  modport slave (
    input  E_mdu_op, E_valid, E_src1, E_src2, D_is_mdu,
    output E_mdu_result, E_mdu_busy, D_mdu_stall
  );

endinterface
`default_nettype wire

// File: rtl/e_mdu_calc.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu_calc
// Description : Combinational 32x32 multiply / divide producing {hi,lo},
//               including the divide-by-zero policy.
//               Option macro: E_MDU_DIVZERO_HOLD_EN (divide by zero leaves
//               HI/LO untouched; otherwise LO=all-ones, HI=dividend).
// Revision    : 1.0 - initial release
// ============================================================================
module e_mdu_calc
  import mdu_pkg::*;
(
  input  mdu_op_e     i_op,
  input  logic [31:0] i_src1,
  input  logic [31:0] i_src2,
  output logic [63:0] o_result,
  output logic        o_write_en
);

  logic        w_signed_mul;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic        w_div_zero;
  logic [31:0] w_divisor;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;

  // Sign/zero-extended operands make a single 64-bit truncated product
  // correct for both signed and unsigned multiplies.
  assign w_signed_mul = (i_op == MDU_MULT);
  assign w_ext_a = w_signed_mul ? {{32{i_src1[31]}}, i_src1} : {32'd0, i_src1};
  assign w_ext_b = w_signed_mul ? {{32{i_src2[31]}}, i_src2} : {32'd0, i_src2};
  assign w_prod  = w_ext_a * w_ext_b;

  // Divisor forced non-zero so the dividers never see a zero operand.
  assign w_div_zero = (i_src2 == 32'd0);
  assign w_divisor  = w_div_zero ? 32'd1 : i_src2;

  // Signed divide on magnitudes; 0x80000000 magnitude is representable
  // unsigned, so MIN / -1 wraps back to 0x80000000 with remainder 0.
  assign w_abs_a = i_src1[31]    ? (~i_src1 + 32'd1)    : i_src1;
  assign w_abs_b = w_divisor[31] ? (~w_divisor + 32'd1) : w_divisor;
  assign w_q_mag = w_abs_a / w_abs_b;
  assign w_r_mag = w_abs_a % w_abs_b;
  assign w_sq    = (i_src1[31] ^ w_divisor[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_sr    = i_src1[31] ? (~w_r_mag + 32'd1) : w_r_mag;

  assign w_uq = i_src1 / w_divisor;
  assign w_ur = i_src1 % w_divisor;

  // Select result by op and apply the divide-by-zero policy
  always_comb begin
    o_result   = 64'd0;
    o_write_en = 1'b1;
    case (i_op)
      MDU_MULT, MDU_MULTU: o_result = w_prod;
      MDU_DIV:             o_result = {w_sr, w_sq};
      MDU_DIVU:            o_result = {w_ur, w_uq};
      default:             o_result = 64'd0;
    endcase
    if (((i_op == MDU_DIV) || (i_op == MDU_DIVU)) && w_div_zero) begin
`ifdef E_MDU_DIVZERO_HOLD_EN
      o_write_en = 1'b0;
`else
      o_result = {i_src1, 32'hFFFF_FFFF};
`endif
    end
  end

endmodule
`default_nettype wire

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu
// Description : E-stage multiply/divide unit. Fixed-latency mult/div with
//               HI/LO registers, mfhi/mflo/mthi/mtlo and Decode stall.
//               Option macro: E_MDU_DIVZERO_HOLD_EN (see e_mdu_calc).
// Revision    : 1.0 - initial release
// ============================================================================
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave mdu
);

  localparam logic [MDU_CNT_W-1:0] C_MULT_LOAD = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] C_DIV_LOAD  = MDU_CNT_W'(DIV_CYCLES);

  logic [MDU_CNT_W-1:0] r_cnt;
  logic                 r_busy;
  logic                 r_pend_we;
  logic [31:0]          r_pend_hi;
  logic [31:0]          r_pend_lo;
  logic [31:0]          r_hi;
  logic [31:0]          r_lo;

  logic                 w_start;
  logic                 w_is_mult;
  logic                 w_mt_hi;
  logic                 w_mt_lo;
  logic [63:0]          w_calc;
  logic                 w_calc_we;
  logic [31:0]          w_result;

  // Any start or move-to arriving while busy is ignored; the Decode stall
  // normally prevents that from happening at all.
  assign w_start   = mdu.E_valid & is_muldiv(mdu.E_mdu_op) & ~r_busy;
  assign w_is_mult = (mdu.E_mdu_op == MDU_MULT) || (mdu.E_mdu_op == MDU_MULTU);
  assign w_mt_hi   = mdu.E_valid & ~r_busy & (mdu.E_mdu_op == MDU_MTHI);
  assign w_mt_lo   = mdu.E_valid & ~r_busy & (mdu.E_mdu_op == MDU_MTLO);

  e_mdu_calc u_calc (
    .i_op       (mdu.E_mdu_op),
    .i_src1     (mdu.E_src1),
    .i_src2     (mdu.E_src2),
    .o_result   (w_calc),
    .o_write_en (w_calc_we)
  );

  // Counter, busy, pending result and HI/LO architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_pend_we <= 1'b0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      if (w_start) begin
        r_pend_hi <= w_calc[63:32];
        r_pend_lo <= w_calc[31:0];
        r_pend_we <= w_calc_we;
        r_cnt     <= w_is_mult ? C_MULT_LOAD : C_DIV_LOAD;
        r_busy    <= 1'b1;
      end else if (r_busy) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == MDU_CNT_W'(1)) begin
          r_busy <= 1'b0;
          if (r_pend_we) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
          end
        end
      end
      if (w_mt_hi) r_hi <= mdu.E_src1;
      if (w_mt_lo) r_lo <= mdu.E_src1;
    end
  end

  // Move-from read mux feeding M_REG
  always_comb begin
    w_result = 32'd0;
    case (mdu.E_mdu_op)
      MDU_MFHI: w_result = r_hi;
      MDU_MFLO: w_result = r_lo;
      default:  w_result = 32'd0;
    endcase
  end

  assign mdu.E_mdu_result = w_result;
  assign mdu.E_mdu_busy   = w_start | r_busy;
  assign mdu.D_mdu_stall  = mdu.D_is_mdu & (w_start | r_busy);

endmodule
`default_nettype wire

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit for the Execute stage of the five-stage MIPS pipeline, placed beside the ALU and feeding M_REG. It executes mult/multu/div/divu over a fixed multi-cycle latency, holds the HI/LO architectural registers, services mfhi/mflo/mthi/mtlo, and tells the hazard unit to stall Decode while it is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10: busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- E_mdu_op  in  4  operation of the E-stage instruction (mdu_pkg encoding): NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- E_valid  in  1  E-stage instruction is real (not a bubble); qualifies E_mdu_op.
- E_src1  in  32  forwarded rs value.
- E_src2  in  32  forwarded rt value.
- D_is_mdu  in  1  D-stage instruction has any non-NONE MDU op.
- E_mdu_result  out  32  HI for MFHI, LO for MFLO, else 0; combinational; routed into M_REG's aluResult mux.
- E_mdu_busy  out  1  start | busy.
- D_mdu_stall  out  1  D_is_mdu & E_mdu_busy.

## Operation
- start = E_valid & op ∈ {MULT,MULTU,DIV,DIVU} & !busy. Start while busy cannot occur, because D_mdu_stall holds the instruction in D; if it does occur it is ignored.
- On start:
  - Compute the 64-bit result from E_src1/E_src2 and latch it into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES and set busy.
- While busy, cnt decrements each edge. On the edge where cnt goes 1→0:
  - HI←pend_hi, LO←pend_lo.
  - busy clears.
- MULT: signed 32×32→64 product, HI = product[63:32], LO = product[31:0]. MULTU: same, unsigned.
- DIV: signed quotient truncated toward zero into LO; remainder into HI, carrying the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient into LO, remainder into HI.
- MTHI/MTLO (E_valid, !busy): HI/LO←E_src1 at the next edge. They are never accepted while busy; the Decode stall guarantees this.
- MFHI/MFLO read the current HI/LO. They are never issued while busy, again because of the Decode stall.
- Reset at any time, including mid-operation: cnt=0, busy=0, HI=0, LO=0, pend_hi=0, pend_lo=0. The in-flight result is discarded.

## Timing
- Reset values: E_mdu_busy=0, D_mdu_stall=0, E_mdu_result=0.
- The start edge is edge T. busy is high in cycles T+1..T+N (N = configured cycles).
- E_mdu_busy is also high in cycle T, because start is combinational. D_mdu_stall therefore covers N+1 cycles.
- The new HI/LO are visible to MFHI/MFLO from cycle T+N+1.
- MTHI/MTLO take effect at the edge after issue: a write at edge T is visible in cycle T+1.
- When the busy-end edge and a pending MT coincide, the MT is blocked (it is stalled), so the multiply/divide result always lands first.

## Configuration
- Macro: E_MDU_DIVZERO_HOLD_EN.
- Defined: a div/divu with E_src2==0 still runs the full DIV_CYCLES busy period, but HI/LO are left unchanged at completion.
- Undefined: divide by zero writes LO=0xFFFFFFFF and HI=E_src1, for both signed and unsigned.

## Structure
- mdu_pkg holds:
  - the 4-bit op encoding enum,
  - default cycle constants MDU_MULT_CYCLES=5 and MDU_DIV_CYCLES=10,
  - counter width 4.
- Sub-module e_mdu_calc: purely combinational; takes op, src1, src2 and produces the 64-bit {hi,lo}, including the divide-by-zero policy. e_mdu owns the counter, busy, pending and HI/LO registers.

## Test plan
- reset, then MULT with src1=0xFFFFFFFE (−2), src2=3 → busy for 5 cycles; then MFHI=0xFFFFFFFF and MFLO=0xFFFFFFFA.
- MULTU with src1=0xFFFFFFFF, src2=2 → HI=1, LO=0xFFFFFFFE. With D_is_mdu=1 held through, D_mdu_stall is high for exactly 6 cycles starting at the start cycle.
- DIV with src1=−7 (0xFFFFFFF9), src2=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles. DIVU with src1=7, src2=2 → LO=3, HI=1.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0, then MFHI/MFLO on the following cycles → read back exactly the written values. DIV by 0 with HI/LO preloaded → values unchanged when E_MDU_DIVZERO_HOLD_EN is defined; LO=0xFFFFFFFF and HI=src1 when it is undefined.
- DIV started, reset asserted in busy cycle 4 → the next cycle shows busy=0, HI=LO=0, and no late write occurs.
- E_valid=0 with E_mdu_op=MULT → no start, and busy stays 0.
